// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues one sram-like request at a time for pc_in and buffers
// returned words (or misaligned-PC exceptions) with their PC in a FIFO feeding decode.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        go_if,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  state_t      r_state;
  logic [AW:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic        r_cancel;
  logic [31:0] r_req_pc;

  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_inst_mem [DEPTH];
  logic        r_adel_mem [DEPTH];

  logic        w_space;
  logic        w_aligned;
  logic        w_adel_push;
  logic        w_data_push;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_pc;
  logic [31:0] w_push_inst;

  assign w_space   = (r_count < (AW+1)'(DEPTH));
  assign w_aligned = (pc_in[1:0] == 2'b00);

  // Requests and go_if are held low during reset so the PC register cannot advance.
  assign inst_req    = ~rst & (r_state == S_REQ) & w_space & ~flush & w_aligned;
  assign w_adel_push = ~rst & (r_state == S_REQ) & w_space & ~flush & ~w_aligned;
  assign w_data_push = (r_state == S_WAIT) & inst_data_ok & ~r_cancel & ~flush;
  assign w_push      = w_adel_push | w_data_push;
  assign w_pop       = id_valid & id_ready & ~flush;

  assign go_if     = (inst_req & inst_addr_ok) | (flush & ~rst);
  assign inst_addr = pc_in;

  assign w_push_pc   = w_adel_push ? pc_in : r_req_pc;
  assign w_push_inst = w_adel_push ? 32'h0 : inst_rdata;

  assign id_valid = (r_count != '0);
  assign id_pc    = id_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign id_inst  = id_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign id_adel  = id_valid & r_adel_mem[r_rd_ptr];

  // NOTE: storage is not reset; outputs are masked by id_valid, which the reset does clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= w_push_pc;
      r_inst_mem[r_wr_ptr] <= w_push_inst;
      r_adel_mem[r_wr_ptr] <= w_adel_push;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_cancel <= 1'b0;
      r_req_pc <= 32'h0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (inst_req && inst_addr_ok) begin
            r_req_pc <= pc_in;
            r_state  <= S_WAIT;
          end else if (w_adel_push) begin
            r_state  <= S_HALT;
          end
        end
        S_WAIT: begin
          // A flush while the response is still pending marks it for discard.
          if (inst_data_ok) begin
            r_cancel <= 1'b0;
            r_state  <= S_REQ;
          end else if (flush) begin
            r_cancel <= 1'b1;
          end
        end
        S_HALT: begin
          if (flush) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, fetch latency, back-pressure, flush/cancel,
// misaligned-PC halt, push/pop across pointer wrap and asynchronous reset mid-transfer.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        go_if;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .go_if        (go_if),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic aok, input logic dok,
                       input logic [31:0] rdata, input logic rdy, input logic fl);
    pc_in        = pc;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    id_ready     = rdy;
    flush        = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state, with addr_ok high to show requests are gated
    cyc();
    check("rst_inst_req", {31'h0, inst_req}, 32'h0);
    check("rst_go_if",    {31'h0, go_if},    32'h0);
    check("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check("rst_id_pc",    id_pc,   32'h0);
    check("rst_id_inst",  id_inst, 32'h0);
    check("rst_id_adel",  {31'h0, id_adel},  32'h0);

    // T1: first fetch right after reset release
    cyc(); rst = 1'b0;
    drive(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_inst_req",  {31'h0, inst_req}, 32'h1);
    check("t1_go_if",     {31'h0, go_if},    32'h1);
    check("t1_inst_addr", inst_addr, 32'hBFC0_0000);
    cyc(); drive(32'hBFC0_0004, 1'b0, 1'b1, 32'h2408_0001, 1'b0, 1'b0);
    check("t1_wait_no_req", {31'h0, inst_req}, 32'h0);
    check("t1_no_bypass",   {31'h0, id_valid}, 32'h0);
    cyc(); drive(32'hBFC0_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_id_valid", {31'h0, id_valid}, 32'h1);
    check("t1_id_pc",    id_pc,   32'hBFC0_0000);
    check("t1_id_inst",  id_inst, 32'h2408_0001);
    check("t1_id_adel",  {31'h0, id_adel}, 32'h0);
    check("t1_idle_go_if", {31'h0, go_if}, 32'h0);

    // T2: fill to four entries with decode stalled
    for (int k = 1; k <= 3; k++) begin
      cyc(); drive(32'hBFC0_0000 + 32'(4 * k), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t2_fill_req", {31'h0, inst_req}, 32'h1);
      cyc(); drive(32'hBFC0_0000 + 32'(4 * k), 1'b0, 1'b1, 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
    end
    cyc(); drive(32'hBFC0_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t2_full_no_req",  {31'h0, inst_req}, 32'h0);
    check("t2_full_no_go",   {31'h0, go_if},    32'h0);
    check("t2_full_head_pc", id_pc, 32'hBFC0_0000);
    cyc(); drive(32'hBFC0_0010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_pop_cycle_no_req", {31'h0, inst_req}, 32'h0);
    cyc(); drive(32'hBFC0_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t2_after_pop_req",  {31'h0, inst_req}, 32'h1);
    check("t2_after_pop_go",   {31'h0, go_if},    32'h1);
    check("t2_after_pop_pc",   id_pc,   32'hBFC0_0004);
    check("t2_after_pop_inst", id_inst, 32'h1000_0001);
    cyc(); drive(32'hBFC0_0014, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t2_single_req", {31'h0, inst_req}, 32'h0);

    // T3: flush while waiting; the late response must be dropped
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_flush_go_if", {31'h0, go_if},    32'h1);
    check("t3_flush_no_req", {31'h0, inst_req}, 32'h0);
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_cleared", {31'h0, id_valid}, 32'h0);
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("t3_wait_no_req", {31'h0, inst_req}, 32'h0);
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_dropped",   {31'h0, id_valid}, 32'h0);
    check("t3_new_req",   {31'h0, inst_req}, 32'h1);
    check("t3_new_addr",  inst_addr, 32'hBFC0_0380);
    cyc(); drive(32'hBFC0_0380, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_new_go", {31'h0, go_if}, 32'h1);
    cyc(); drive(32'hBFC0_0384, 1'b0, 1'b1, 32'h3C1A_0000, 1'b0, 1'b0);
    cyc(); drive(32'hBFC0_0384, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_new_pc",   id_pc,   32'hBFC0_0380);
    check("t3_new_inst", id_inst, 32'h3C1A_0000);

    // T4: misaligned PC raises AdEL and halts until flush
    cyc(); drive(32'hBFC0_0002, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_no_req",   {31'h0, inst_req}, 32'h0);
    check("t4_no_go",    {31'h0, go_if},    32'h0);
    cyc(); drive(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_valid",    {31'h0, id_valid}, 32'h1);
    check("t4_adel",     {31'h0, id_adel},  32'h1);
    check("t4_pc",       id_pc,   32'hBFC0_0002);
    check("t4_inst",     id_inst, 32'h0);
    check("t4_halt_req", {31'h0, inst_req}, 32'h0);
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t4_flush_go", {31'h0, go_if}, 32'h1);
    cyc(); drive(32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_flushed",  {31'h0, id_valid}, 32'h0);
    check("t4_resume",   {31'h0, inst_req}, 32'h1);

    // T5: hold two entries, push and pop together across pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(); drive(32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t5_req", {31'h0, inst_req}, 32'h1);
      cyc(); drive(32'h8000_0000 + 32'(4 * i), 1'b0, 1'b1, 32'hA000_0000 + 32'(i),
                   (i >= 2) ? 1'b1 : 1'b0, 1'b0);
      if (i >= 2) begin
        check("t5_head_pc",   id_pc,   32'h8000_0000 + 32'(4 * (i - 2)));
        check("t5_head_inst", id_inst, 32'hA000_0000 + 32'(i - 2));
      end
    end
    cyc(); drive(32'h8000_0028, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_drain0_pc", id_pc, 32'h8000_0020);
    cyc(); drive(32'h8000_0028, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_drain1_pc",   id_pc,   32'h8000_0024);
    check("t5_drain1_inst", id_inst, 32'hA000_0009);
    cyc(); drive(32'h8000_0028, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_empty", {31'h0, id_valid}, 32'h0);

    // T6: asynchronous reset while a request is outstanding
    cyc(); drive(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(); drive(32'hBFC0_0004, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    cyc(); drive(32'hBFC0_0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(); drive(32'hBFC0_0008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_pre_valid", {31'h0, id_valid}, 32'h1);
    check("t6_pre_wait",  {31'h0, inst_req}, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("t6_inst_req", {31'h0, inst_req}, 32'h0);
    check("t6_go_if",    {31'h0, go_if},    32'h0);
    check("t6_id_valid", {31'h0, id_valid}, 32'h0);
    check("t6_id_pc",    id_pc,   32'h0);
    check("t6_id_inst",  id_inst, 32'h0);
    check("t6_id_adel",  {31'h0, id_adel}, 32'h0);
    cyc(); rst = 1'b0;
    drive(32'hBFC0_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_state_req", {31'h0, inst_req}, 32'h1);
    check("t6_empty",     {31'h0, id_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
